uart_tx: RTL and testbench
==========================

# uart_tx

Parametrised UART transmitter that drains a show-ahead egress FIFO and serialises each entry onto `txd`, LSB first. It supersedes the fixed 8N1 sender with run-time bit divisor, parity mode, stop-bit count and line break, and a configurable data width. It sits between the egress FIFO and the board TX pin.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `DIV_W`, 16, width of the clocks-per-bit divisor.
- `clk  in  1`  sole clock.
- `rst_n  in  1`  reset, synchronous, active-low.
- `eg_data  in  DATA_BITS`  FIFO head word; valid whenever `eg_empty`=0 (show-ahead).
- `eg_empty  in  1`  FIFO empty flag.
- `eg_rd_en  out  1`  pop strobe; one cycle per accepted word.
- `cfg_div  in  DIV_W`  clocks per bit; 0 is treated as 1.
- `cfg_parity  in  2`  0 = none, 1 = even, 2 = odd, 3 = none.
- `cfg_stop2  in  1`  1 = two stop bits, 0 = one stop bit.
- `cfg_break  in  1`  hold the line low while idle.
- `txd  out  1`  serial output; idle high.
- `active  out  1`  high from the start bit through the last stop bit.
- `done  out  1`  one-cycle pulse when a frame completes.

## Operation
- Reset (`rst_n`=0 at a clock edge), regardless of current state:
  - `txd`=1, `active`=0, `done`=0, `eg_rd_en`=0.
  - State goes to IDLE; all counters clear.
  - A frame in progress is abandoned, with no `done`.
- States are IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE:
  - `txd`=1, or 0 if `cfg_break`=1.
  - `eg_rd_en` = IDLE & !`eg_empty` & !`cfg_break`. This is combinational from the registered state and the inputs.
  - On an edge with `eg_rd_en`=1, the block latches `eg_data`, `cfg_div`, `cfg_parity` and `cfg_stop2`, sets `active`, and goes to START.
- Config changes during a frame have no effect until the next frame's latch.
- START: `txd`=0 for div cycles, then DATA.
- DATA:
  - `txd` = data[idx] for div cycles per bit, with idx running 0..DATA_BITS-1.
  - After the last bit, go to PARITY if parity is enabled, else STOP.
- PARITY: `txd` is held for div cycles.
  - Even parity: `txd` = XOR of the data bits.
  - Odd parity: `txd` = XNOR of the data bits.
- STOP:
  - `txd`=1 for div cycles, or 2·div cycles if stop2 is latched.
  - After the last stop cycle, go to IDLE, clear `active`, and pulse `done` for that IDLE cycle.
- `cfg_break` is sampled only in IDLE. Asserting it mid-frame does not corrupt the frame; the break takes effect after STOP.
- Bit counter arithmetic:
  - The counter is DIV_W bits and counts 0..div-1.
  - An effective div of 0 becomes 1.
  - There is no wrap hazard, because the compare is against latched div-1.

## Timing
- Word presented to an idle block, with FIFO non-empty and no break:
  - `eg_rd_en` is high in the same cycle.
  - `txd` falls on the next edge.
- Frame length is div·(1 + DATA_BITS + P + S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `done` is high for exactly 1 cycle, coincident with the first IDLE cycle. `eg_rd_en` may assert in that same cycle.
- Back-to-back frames:
  - Consecutive `eg_rd_en` pulses are frame length + 1 cycles apart.
  - The line is high for exactly 1 cycle between the last stop bit and the next start bit.
- `eg_rd_en` is never high outside IDLE or during reset. At most one pop occurs per frame.

## Structure
- Shared package `common`:
  - `uart_tx_st_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Parity constants `PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2.
- Sub-module `uart_baud_cnt` (DIV_W):
  - Inputs: load, latched div.
  - Output: `bit_end` pulse on the div-th cycle.
  - The FSM, shift/index logic and parity fold stay in `uart_tx`.

## Test plan
- 8N1, div=4, FIFO={0xA5}:
  - One `eg_rd_en` pulse.
  - `txd`: 4 cycles low, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles high.
  - `done` pulses once, 40 cycles after the pop edge; `active` is high for exactly 40 cycles.
- Parity, div=2, data 0x07:
  - Even: parity slot = 1.
  - Odd: parity slot = 0.
  - Frame length is 22 cycles in both cases.
- cfg_stop2=1, div=3, 8N: stop high for 6 cycles; frame length 33.
- Back-to-back, 3 words, 8N1, div=1:
  - Pops are exactly 11 cycles apart.
  - Exactly one high idle cycle between frames.
  - 3 `done` pulses.
- Break and divisor edge cases:
  - `cfg_break`=1 with FIFO non-empty: `txd`=0, no pops.
  - Release: the frame starts the next cycle.
  - `cfg_div`=0 behaves identically to div=1.
- `rst_n` low mid-DATA:
  - The next cycle shows `txd`=1, `active`=0, `done`=0.
  - No extra pop occurs.
  - The following frame is transmitted correctly.
- The DATA_BITS=7 instance with 0x55 produces 7 data slots.

Source files
------------

// File: rtl/common.sv
// rtl/common.sv - shared UART transmitter types and parity constants
package common;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_st_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - clocks-per-bit counter, pulses bit_end on the last cycle of a bit
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div_m1,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt;

  // Compare against the latched div-1 so the count never has to wrap
  assign bit_end = !load && (cnt == div_m1);

  always_ff @(posedge clk) begin
    if (!rst_n || load || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter draining a show-ahead egress FIFO onto txd, LSB first
module uart_tx
  import common::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] eg_data,
  input  logic                 eg_empty,
  output logic                 eg_rd_en,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 cfg_break,
  output logic                 txd,
  output logic                 active,
  output logic                 done
);

  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

  uart_tx_st_t          state, state_nx;
  logic [DATA_BITS-1:0] shreg;
  logic [DIV_W-1:0]     div_m1;
  logic [3:0]           bit_idx;
  logic                 par_en_q, par_bit, stop2_q, stop_second;
  logic                 bit_end, pop, frame_end, done_q;

  assign pop      = rst_n && (state == IDLE) && !eg_empty && !cfg_break;
  assign eg_rd_en = pop;
  assign active   = (state != IDLE);
  assign done     = done_q;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == IDLE),
    .div_m1  (div_m1),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    txd       = 1'b1;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        txd = !cfg_break;
        if (pop) state_nx = START;
      end
      START: begin
        txd = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        txd = shreg[0];
        if (bit_end && (bit_idx == LAST_IDX)) state_nx = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        txd = par_bit;
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        txd = 1'b1;
        if (bit_end && (!stop2_q || stop_second)) begin
          state_nx  = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame settings are captured at the pop so mid-frame config changes are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg       <= '0;
      div_m1      <= '0;
      bit_idx     <= '0;
      par_en_q    <= 1'b0;
      par_bit     <= 1'b0;
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (pop) begin
        shreg       <= eg_data;
        div_m1      <= (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
        bit_idx     <= '0;
        par_en_q    <= parity_on(cfg_parity);
        par_bit     <= (^eg_data) ^ (cfg_parity == PAR_ODD);
        stop2_q     <= cfg_stop2;
        stop_second <= 1'b0;
      end else if (bit_end) begin
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 4'd1;
        end
        if (state == STOP) stop_second <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a slot-based frame model
module tb_uart_tx;

  typedef struct {
    logic [8:0] d;
    int         nb;
    int         dv;
    int         par;
    bit         s2;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eg_data;
  logic        eg_empty, eg_rd_en;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2, cfg_break;
  logic        txd, active, done;
  logic [6:0]  eg7_data;
  logic        eg7_empty, eg7_rd_en, txd7, active7, done7;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .DIV_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .eg_data(eg_data), .eg_empty(eg_empty), .eg_rd_en(eg_rd_en),
    .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_break(cfg_break),
    .txd(txd), .active(active), .done(done)
  );

  uart_tx #(.DATA_BITS(7), .DIV_W(16)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .eg_data(eg7_data), .eg_empty(eg7_empty), .eg_rd_en(eg7_rd_en),
    .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_break(cfg_break),
    .txd(txd7), .active(active7), .done(done7)
  );

  // Reference model: a frame is a sequence of slots, each eff_div cycles long
  function automatic int eff_div(input int dv);
    return (dv == 0) ? 1 : dv;
  endfunction

  function automatic int frame_len(input frame_t f);
    return eff_div(f.dv) * (1 + f.nb + ((f.par == 1 || f.par == 2) ? 1 : 0) + (f.s2 ? 2 : 1));
  endfunction

  function automatic logic exp_bit(input frame_t f, input int k);
    int   slot;
    logic p;
    slot = k / eff_div(f.dv);
    p    = (f.par == 2);
    if (slot == 0) return 1'b0;
    if (slot <= f.nb) return f.d[slot-1];
    if ((f.par == 1 || f.par == 2) && slot == f.nb + 1) begin
      for (int i = 0; i < f.nb; i++) p = p ^ f.d[i];
      return p;
    end
    return 1'b1;
  endfunction

  // Scoreboard storage: stimulus owns the write side, monitor owns the read side
  frame_t exp_arr[256];
  int     exp_wr = 0;
  int     exp_rd = 0;
  string  req_nm[256];
  int     req_act[256];
  int     req_exp[256];
  int     req_n = 0;
  int     req_rd = 0;
  int     pop_cyc[256];
  int     pop_n = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     spurious = 0;
  bit     in_frame = 0;
  bit     post_rst = 0;
  int     k, flen, terr, aerr;
  frame_t cur;
  logic [7:0] fifo[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    while (req_rd < req_n) begin
      check(req_nm[req_rd], req_act[req_rd], req_exp[req_rd]);
      req_rd++;
    end
    if (post_rst) begin
      check("rst_txd", int'(txd), 1);
      check("rst_active", int'(active), 0);
      check("rst_done", int'(done), 0);
      post_rst = 0;
    end
    if (!rst_n) begin
      in_frame = 0;
      post_rst = 1;
      if (eg_rd_en) spurious++;
    end else begin
      if (in_frame) begin
        if (k < flen) begin
          if (txd !== exp_bit(cur, k)) terr++;
          if (active !== 1'b1 || done !== 1'b0) aerr++;
          if (eg_rd_en) spurious++;
          k++;
        end else begin
          check("frame_txd_errors", terr, 0);
          check("frame_active_errors", aerr, 0);
          check("done_at_frame_len", int'(done), 1);
          check("active_after_frame", int'(active), 0);
          check("idle_gap_txd", int'(txd), int'(!cfg_break));
          in_frame = 0;
        end
      end else if (done) begin
        spurious++;
      end
      if (!in_frame && eg_rd_en) begin
        if (exp_rd >= exp_wr) begin
          spurious++;
        end else begin
          cur = exp_arr[exp_rd];
          exp_rd++;
          in_frame = 1;
          k = 0;
          flen = frame_len(cur);
          terr = 0;
          aerr = 0;
          pop_cyc[pop_n] = cyc;
          pop_n++;
        end
      end
    end
  end

  task automatic req(input string nm, input int act, input int expv);
    req_nm[req_n]  = nm;
    req_act[req_n] = act;
    req_exp[req_n] = expv;
    req_n++;
  endtask

  task automatic refresh();
    eg_empty = (fifo.size() == 0);
    eg_data  = eg_empty ? 8'h00 : fifo[0];
  endtask

  task automatic step();
    logic p;
    @(negedge clk);
    p = eg_rd_en;
    @(posedge clk);
    #1;
    if (p && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
  endtask

  task automatic send(input logic [7:0] d);
    fifo.push_back(d);
    exp_arr[exp_wr] = '{d: {1'b0, d}, nb: 8, dv: int'(cfg_div), par: int'(cfg_parity), s2: bit'(cfg_stop2)};
    exp_wr++;
    refresh();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || in_frame) && n < budget) begin
      step();
      n++;
    end
    req("drain_in_budget", int'(n < budget), 1);
    step();
  endtask

  initial begin
    int     p0, errs, nw;
    frame_t f7;
    rst_n = 1'b0;
    cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0; cfg_break = 1'b0;
    eg7_data = 7'h00; eg7_empty = 1'b1;
    refresh();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 8N1, div 4, 0xA5
    p0 = pop_n;
    send(8'hA5);
    drain(200);
    req("a5_pop_count", pop_n - p0, 1);

    // Parity even/odd, div 2, 0x07
    cfg_div = 16'd2; cfg_parity = 2'd1;
    send(8'h07); drain(200);
    cfg_parity = 2'd2;
    send(8'h07); drain(200);

    // Two stop bits, div 3
    cfg_div = 16'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
    send(8'h3C); drain(200);

    // Back-to-back, div 1
    cfg_div = 16'd1; cfg_stop2 = 1'b0;
    p0 = pop_n;
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
    drain(200);
    req("b2b_pop_count", pop_n - p0, 3);
    req("b2b_spacing_1", pop_cyc[p0+1] - pop_cyc[p0], 11);
    req("b2b_spacing_2", pop_cyc[p0+2] - pop_cyc[p0+1], 11);

    // Break holds the line low and blocks pops
    cfg_break = 1'b1;
    p0 = pop_n;
    send(8'h5A);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (txd !== 1'b0) errs++;
    end
    req("break_txd_low", errs, 0);
    req("break_no_pop", pop_n - p0, 0);
    cfg_break = 1'b0;
    #1;
    req("release_rd_en", int'(eg_rd_en), 1);
    drain(200);

    // div 0 behaves as div 1
    cfg_div = 16'd0;
    send(8'($urandom_range(0, 255)));
    drain(200);

    // Reset mid-DATA abandons the frame
    cfg_div = 16'd2;
    p0 = pop_n;
    send(8'hC3);
    repeat (6) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    req("rst_single_pop", pop_n - p0, 1);
    send(8'h96);
    drain(200);

    // Randomised frames and bursts
    for (int t = 0; t < 20; t++) begin
      cfg_div    = 16'($urandom_range(0, 5));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) send(8'($urandom_range(0, 255)));
      drain(400);
    end

    // Seven-bit instance, 0x55, 7N1 at div 1
    cfg_div = 16'd1; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    eg7_data = 7'h55; eg7_empty = 1'b0;
    #1;
    req("dut7_rd_en", int'(eg7_rd_en), 1);
    @(posedge clk); #1;
    eg7_empty = 1'b1;
    f7 = '{d: 9'h055, nb: 7, dv: 1, par: 0, s2: 1'b0};
    errs = 0;
    for (int i = 0; i < frame_len(f7); i++) begin
      if (txd7 !== exp_bit(f7, i) || active7 !== 1'b1) errs++;
      @(posedge clk); #1;
    end
    req("dut7_frame_errors", errs, 0);
    req("dut7_done", int'(done7), 1);

    req("spurious_events", spurious, 0);
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
